// File: rtl/cond_exec_ctrl.sv
// ARM-style conditional execution controller: evaluates the condition field against the
// NZCV flags, then issues or annuls the instruction. Optional macro COND_NV_NEVER_EN makes cond=4'hF never pass.
module cond_exec_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_cond,
    input  logic             in_s,
    output logic             iss_valid,
    input  logic             iss_ready,
    output logic             iss_annul,
    input  logic             wb_valid,
    input  logic [3:0]       wb_nzcv,
    input  logic             psr_we,
    input  logic [3:0]       psr_nzcv,
    output logic [3:0]       flags,
    output logic             busy,
    output logic [CNT_W-1:0] exec_cnt,
    output logic [CNT_W-1:0] skip_cnt
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_WB} state_t;

    state_t state, state_nx;
    logic   s_lat;
    logic   cond_pass;
    logic   accept, iss_fire, wb_take;
    logic   n, z, c, v;

    assign {n, z, c, v} = flags;

    always_comb begin
        cond_pass = 1'b0;
        case (in_cond)
            4'h0: cond_pass = z;
            4'h1: cond_pass = !z;
            4'h2: cond_pass = c;
            4'h3: cond_pass = !c;
            4'h4: cond_pass = n;
            4'h5: cond_pass = !n;
            4'h6: cond_pass = v;
            4'h7: cond_pass = !v;
            4'h8: cond_pass = c && !z;
            4'h9: cond_pass = !c || z;
            4'hA: cond_pass = (n == v);
            4'hB: cond_pass = (n != v);
            4'hC: cond_pass = !z && (n == v);
            4'hD: cond_pass = z || (n != v);
            4'hE: cond_pass = 1'b1;
            4'hF: begin
`ifdef COND_NV_NEVER_EN
                cond_pass = 1'b0;
`else
                cond_pass = 1'b1;
`endif
            end
            default: cond_pass = 1'b0;
        endcase
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        iss_valid = 1'b0;
        busy      = 1'b1;
        accept    = 1'b0;
        iss_fire  = 1'b0;
        wb_take   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                accept   = in_valid;
                if (in_valid && cond_pass)
                    state_nx = ISSUE;
            end
            ISSUE: begin
                iss_valid = 1'b1;
                iss_fire  = iss_ready;
                if (iss_ready)
                    state_nx = s_lat ? WAIT_WB : IDLE;
            end
            WAIT_WB: begin
                wb_take = wb_valid;
                if (wb_valid)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            flags     <= 4'b0000;
            s_lat     <= 1'b0;
            iss_annul <= 1'b0;
            exec_cnt  <= '0;
            skip_cnt  <= '0;
        end else begin
            state     <= state_nx;
            iss_annul <= accept && !cond_pass;
            if (accept && cond_pass)
                s_lat <= in_s;
            // ALU writeback outranks a concurrent MSR write
            if (wb_take)
                flags <= wb_nzcv;
            else if (psr_we)
                flags <= psr_nzcv;
            if (iss_fire && exec_cnt != '1)
                exec_cnt <= exec_cnt + 1'b1;
            if (accept && !cond_pass && skip_cnt != '1)
                skip_cnt <= skip_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_cond_exec_ctrl.sv
// Randomized bench for cond_exec_ctrl against a transaction-level reference model.
module tb_cond_exec_ctrl;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid, in_s, iss_ready, wb_valid, psr_we;
    logic [3:0]       in_cond, wb_nzcv, psr_nzcv;
    logic             in_ready, iss_valid, iss_annul, busy;
    logic [3:0]       flags;
    logic [CNT_W-1:0] exec_cnt, skip_cnt;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    cond_exec_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_cond(in_cond), .in_s(in_s),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_annul(iss_annul),
        .wb_valid(wb_valid), .wb_nzcv(wb_nzcv),
        .psr_we(psr_we), .psr_nzcv(psr_nzcv),
        .flags(flags), .busy(busy), .exec_cnt(exec_cnt), .skip_cnt(skip_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    // ARM encoding: even codes are a base predicate, odd codes its negation
    function automatic bit arm_pass(input logic [3:0] cond, input logic [3:0] f);
        bit nf, zf, cf, vf, base;
        {nf, zf, cf, vf} = f;
        if (cond == 4'hE) return 1'b1;
        if (cond == 4'hF) begin
`ifdef COND_NV_NEVER_EN
            return 1'b0;
`else
            return 1'b1;
`endif
        end
        case (cond >> 1)
            0: base = zf;
            1: base = cf;
            2: base = nf;
            3: base = vf;
            4: base = cf & ~zf;
            5: base = (nf == vf);
            default: base = ~zf & (nf == vf);
        endcase
        return cond[0] ? ~base : base;
    endfunction

    // reference model: pending-instruction bookkeeping
    bit       m_issuing, m_waiting, m_s, m_annul;
    bit [3:0] m_flags;
    int       m_exec, m_skip;
    localparam int CMAX = (1 << CNT_W) - 1;

    task automatic model_reset();
        m_issuing = 0; m_waiting = 0; m_s = 0; m_annul = 0;
        m_flags = 4'b0; m_exec = 0; m_skip = 0;
    endtask

    task automatic model_step();
        bit idle;
        bit [3:0] f_old;
        if (rst) begin
            model_reset();
            return;
        end
        idle  = !m_issuing && !m_waiting;
        f_old = m_flags;
        m_annul = 0;
        if (m_waiting && wb_valid) m_flags = wb_nzcv;
        else if (psr_we)           m_flags = psr_nzcv;
        if (m_waiting && wb_valid) m_waiting = 0;
        if (m_issuing && iss_ready) begin
            m_issuing = 0;
            m_waiting = m_s;
            if (m_exec < CMAX) m_exec++;
        end
        if (idle && in_valid) begin
            if (arm_pass(in_cond, f_old)) begin
                m_issuing = 1;
                m_s = in_s;
            end else begin
                m_annul = 1;
                if (m_skip < CMAX) m_skip++;
            end
        end
    endtask

    task automatic compare_all();
        bit idle;
        idle = !m_issuing && !m_waiting;
        chk("in_ready",  32'(in_ready),  32'(idle));
        chk("busy",      32'(busy),      32'(!idle));
        chk("iss_valid", 32'(iss_valid), 32'(m_issuing));
        chk("iss_annul", 32'(iss_annul), 32'(m_annul));
        chk("flags",     32'(flags),     32'(m_flags));
        chk("exec_cnt",  32'(exec_cnt),  32'(m_exec));
        chk("skip_cnt",  32'(skip_cnt),  32'(m_skip));
    endtask

    task automatic drive_idle();
        in_valid = 0; in_cond = 4'h0; in_s = 0; iss_ready = 0;
        wb_valid = 0; wb_nzcv = 4'h0; psr_we = 0; psr_nzcv = 4'h0;
    endtask

    initial begin
        rst = 1'b1;
        drive_idle();
        repeat (3) @(posedge clk);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        // reset-state checks
        compare_all();
        model_step();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            compare_all();
            rst       = ($urandom_range(299, 0) == 0);
            in_valid  = ($urandom_range(99, 0) < 70);
            in_cond   = 4'($urandom_range(15, 0));
            in_s      = $urandom_range(1, 0) == 1;
            iss_ready = ($urandom_range(99, 0) < 60);
            wb_valid  = ($urandom_range(99, 0) < 40);
            wb_nzcv   = 4'($urandom_range(15, 0));
            psr_we    = ($urandom_range(99, 0) < 20);
            psr_nzcv  = 4'($urandom_range(15, 0));
            model_step();
        end
        @(negedge clk);
        compare_all();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
